stack_arbiter: RTL and testbench
================================

Name: stack_arbiter

Overview:
- Controller that shares the 32-bit push/pop stack between two requesters: req 0 is the control unit (CALL/RET) and req 1 is the exception unit.
- Sequences the stack's StackPush/StackPop strobes one operation at a time.
- Tracks occupancy, blocks overflow/underflow and captures pop data.
- Provides a flush sequence that drains the stack.

Parameters:
- DW, 32, data width of stack entries.
- DEPTH, 31, max entries admitted. The stack pointer is 5 bits, so the usable depth is 31.
- CW, 6, occupancy counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request.
- req_op  in  2  per-requester op: 0 = push, 1 = pop.
- req_data0  in  DW  push data, requester 0.
- req_data1  in  DW  push data, requester 1.
- req_ready  out  2  one-cycle grant/accept pulse.
- req_err  out  2  one-cycle pulse with req_ready when the op was rejected (full push / empty pop).
- resp_valid  out  2  pop result valid, held until resp_ready.
- resp_ready  in  2  requester consumes pop result.
- resp_data  out  DW  popped value (shared bus, qualified by resp_valid).
- stack_push  out  1  to stack StackPush.
- stack_pop  out  1  to stack StackPop.
- stack_in  out  DW  to stack In.
- stack_out  in  DW  from stack Out.
- flush  in  1  request to drain all entries.
- flush_done  out  1  one-cycle pulse at end of flush.
- count  out  CW  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- err_sticky  out  1  set on any rejected op; cleared by err_clr.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Reset: all outputs 0, state IDLE, count 0, arbiter pointer = requester 0. Reset is asynchronous and may occur in any state.
- Reset mid-operation aborts the operation, clears all state and drops any pending resp_valid.
- After reset the stack contents are undefined to the controller. Software issues flush before use only when reset occurred with count ≠ 0.
- All outputs are registered.
- States: IDLE, ISSUE, POP_WAIT, RESP, FLUSH.
- IDLE, flush high: enter FLUSH. Flush has priority over requests.
- IDLE, any req_valid: the arbiter picks g. Next cycle (state ISSUE):
  - req_ready[g] = 1.
  - Legal push: stack_push = 1, stack_in = req_data_g, count+1.
  - Legal pop: stack_pop = 1, count-1.
  - Illegal op (push when full, pop when empty): no strobe, req_err[g] = 1, err_sticky set, count unchanged.
- ISSUE → IDLE for a push or illegal op.
- ISSUE → POP_WAIT for a legal pop.
- POP_WAIT: capture stack_out into resp_data (stack Out updates on the strobe edge).
- RESP: resp_valid[g] = 1 until resp_ready[g]. Then → IDLE.
- Latencies:
  - Push accept: 1 cycle from IDLE sampling to req_ready.
  - Pop result: resp_valid 3 cycles after the request is sampled.
  - Throughput: one push per 2 cycles.
- Requesters hold req_valid/op/data stable until req_ready. Dropping req_valid before grant is allowed.
- FLUSH: stack_pop = 1 every cycle while count > 0, decrementing count; no responses. When count reaches 0, flush_done pulses and state → IDLE. Flush with count = 0 pulses flush_done in 1 cycle.
- stack_push and stack_pop are never high together and never exceed one cycle per operation.
- err_clr and a new error in the same cycle: set wins.
- count saturates logically at 0..DEPTH; it never wraps.

Optional Feature:
- Macro: STACK_ARB_RR_EN.
- Defined: round-robin arbitration. The pointer moves to the other requester after each grant, including error grants.
- Undefined: fixed priority, requester 1 (exception) always wins. The pointer logic is absent.

Decomposition:
- Package stack_arb_pkg:
  - State enum: IDLE, ISSUE, POP_WAIT, RESP, FLUSH.
  - OP_PUSH = 1'b0, OP_POP = 1'b1.
  - DW, DEPTH, CW defaults.
- Sub-module stack_arb_sel: 2-way grant selection, combinational request mask plus pointer register. It contains the STACK_ARB_RR_EN conditional logic.

Test Plan:
- Req0 push 0xA5A5_0001 then pop: stack_push pulses with stack_in = 0xA5A5_0001; count 1→0; resp_valid[0] with resp_data = 0xA5A5_0001.
- 31 pushes then a 32nd push: full = 1, 32nd gets req_ready + req_err, no stack_push, err_sticky = 1. err_clr → 0.
- Pop when empty: req_err pulse, no stack_pop, no resp_valid, count stays 0.
- Both requesters push every cycle:
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: requester 1 is granted until it drops.
- Push 5 entries, assert flush: exactly 5 consecutive stack_pop pulses, then flush_done, count = 0, empty = 1.
- rst_n low during RESP with resp_ready = 0: resp_valid drops immediately (async). All outputs are 0 and count is 0 after release.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types and defaults for the stack arbiter.
// Optional round-robin arbitration is selected with STACK_ARB_RR_EN.
package stack_arb_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 31;
  localparam int CW_DEF    = 6;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    POP_WAIT = 3'd2,
    RESP     = 3'd3,
    FLUSH    = 3'd4
  } state_e;

endpackage

// File: rtl/stack_arb_sel.sv
// Two-way grant selection for the stack arbiter.
// STACK_ARB_RR_EN defined: round-robin pointer; undefined: requester 1 always wins.
module stack_arb_sel
  import stack_arb_pkg::*;
(
`ifdef STACK_ARB_RR_EN
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       adv_i,
`endif
  input  logic [1:0] req_i,
  output logic       gnt_o
);

`ifdef STACK_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d = adv_i ? ~gnt_o : ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
`else
  // With no request the value is a don't-care; the top only uses it on a grant.
  assign gnt_o = req_i[1] | ~req_i[0];
`endif

endmodule

// File: rtl/stack_arbiter.sv
// Shares one push/pop stack between the control unit (req 0) and exception unit (req 1).
// Arbitration mode is chosen by STACK_ARB_RR_EN (round-robin when defined, fixed otherwise).
//
// state    | meaning
// IDLE     | waiting for flush or a request; samples and arbitrates
// ISSUE    | grant pulse; push/pop strobe or error pulse is on the outputs
// POP_WAIT | stack Out now holds the popped entry; capture it
// RESP     | resp_valid held for the granted requester until resp_ready
// FLUSH    | pop one entry per cycle until empty, then pulse flush_done
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  output logic [1:0]    req_ready,
  output logic [1:0]    req_err,
  output logic [1:0]    resp_valid,
  input  logic [1:0]    resp_ready,
  output logic [DW-1:0] resp_data,
  output logic          stack_push,
  output logic          stack_pop,
  output logic [DW-1:0] stack_in,
  input  logic [DW-1:0] stack_out,
  input  logic          flush,
  output logic          flush_done,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_sticky,
  input  logic          err_clr
);

  state_e        state_q, state_d;
  logic          g_q, g_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    req_ready_q, req_ready_d;
  logic [1:0]    req_err_q, req_err_d;
  logic [1:0]    resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic [DW-1:0] stack_in_q, stack_in_d;
  logic          stack_push_q, stack_push_d;
  logic          stack_pop_q, stack_pop_d;
  logic          flush_done_q, flush_done_d;
  logic          full_q, empty_q;
  logic          err_sticky_q, err_sticky_d;
  logic          err_new;

  logic [1:0]    req_masked;
  logic          grant_now;
  logic          sel_gnt;
  logic          cnt_full, cnt_empty;

  // Requests are only visible to the selector when IDLE and no flush is pending.
  assign req_masked = (state_q == IDLE && !flush) ? req_valid : 2'b00;
  assign grant_now  = |req_masked;
  assign cnt_full   = (count_q == CW'(DEPTH));
  assign cnt_empty  = (count_q == '0);

  stack_arb_sel u_sel (
`ifdef STACK_ARB_RR_EN
    .clk_i  (clk),
    .rst_ni (rst_n),
    .adv_i  (grant_now),
`endif
    .req_i  (req_masked),
    .gnt_o  (sel_gnt)
  );

  always_comb begin
    state_d      = state_q;
    g_d          = g_q;
    count_d      = count_q;
    req_ready_d  = 2'b00;
    req_err_d    = 2'b00;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    stack_in_d   = stack_in_q;
    stack_push_d = 1'b0;
    stack_pop_d  = 1'b0;
    flush_done_d = 1'b0;
    err_new      = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (grant_now) begin
          state_d              = ISSUE;
          g_d                  = sel_gnt;
          req_ready_d[sel_gnt] = 1'b1;
          if (req_op[sel_gnt] == OP_PUSH) begin
            if (cnt_full) begin
              req_err_d[sel_gnt] = 1'b1;
              err_new            = 1'b1;
            end else begin
              stack_push_d = 1'b1;
              stack_in_d   = sel_gnt ? req_data1 : req_data0;
              count_d      = count_q + CW'(1);
            end
          end else begin
            if (cnt_empty) begin
              req_err_d[sel_gnt] = 1'b1;
              err_new            = 1'b1;
            end else begin
              stack_pop_d = 1'b1;
              count_d     = count_q - CW'(1);
            end
          end
        end
      end
      ISSUE: begin
        state_d = stack_pop_q ? POP_WAIT : IDLE;
      end
      POP_WAIT: begin
        resp_data_d       = stack_out;
        resp_valid_d[g_q] = 1'b1;
        state_d           = RESP;
      end
      RESP: begin
        if (resp_ready[g_q]) begin
          resp_valid_d = 2'b00;
          state_d      = IDLE;
        end
      end
      FLUSH: begin
        if (!cnt_empty) begin
          stack_pop_d = 1'b1;
          count_d     = count_q - CW'(1);
        end else begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as err_clr leaves the flag set.
    err_sticky_d = err_new | (err_sticky_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      g_q          <= 1'b0;
      count_q      <= '0;
      req_ready_q  <= 2'b00;
      req_err_q    <= 2'b00;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      stack_in_q   <= '0;
      stack_push_q <= 1'b0;
      stack_pop_q  <= 1'b0;
      flush_done_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      g_q          <= g_d;
      count_q      <= count_d;
      req_ready_q  <= req_ready_d;
      req_err_q    <= req_err_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      stack_in_q   <= stack_in_d;
      stack_push_q <= stack_push_d;
      stack_pop_q  <= stack_pop_d;
      flush_done_q <= flush_done_d;
      full_q       <= (count_d == CW'(DEPTH));
      empty_q      <= (count_d == '0);
      err_sticky_q <= err_sticky_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign req_err    = req_err_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign stack_push = stack_push_q;
  assign stack_pop  = stack_pop_q;
  assign stack_in   = stack_in_q;
  assign flush_done = flush_done_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: stimulus queues expected events, a monitor checks them.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int DW = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req_valid, req_op, req_ready, req_err, resp_valid, resp_ready;
  logic [DW-1:0] req_data0, req_data1, resp_data, stack_in, stack_out;
  logic          stack_push, stack_pop, flush, flush_done, full, empty, err_sticky, err_clr;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  stack_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_data0(req_data0), .req_data1(req_data1), .req_ready(req_ready), .req_err(req_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_in(stack_in), .stack_out(stack_out),
    .flush(flush), .flush_done(flush_done), .count(count), .full(full), .empty(empty),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  // Behavioural stack: Out shows the popped entry after the pop edge.
  logic [DW-1:0] mem [0:63];
  int sp = 0;
  initial stack_out = '0;
  always @(posedge clk) begin
    if (stack_push) begin
      mem[sp] <= stack_in;
      sp      <= sp + 1;
    end else if (stack_pop && sp > 0) begin
      stack_out <= mem[sp-1];
      sp        <= sp - 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  typedef enum int {EV_ACK, EV_PUSH, EV_POP, EV_RESP, EV_FDONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          idx;
    int          err;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

`ifdef STACK_ARB_RR_EN
  int order[5] = '{0, 1, 0, 1, 0};
  int quota[2] = '{3, 2};
`else
  int order[5] = '{1, 1, 1, 1, 0};
  int quota[2] = '{1, 4};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_ev(input ev_kind_e k, input int idx, input int err, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.idx = idx; e.err = err; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic see_ev(input ev_kind_e k, input int idx, input int err, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d idx %0d err %0d data 0x%0h, expected none",
               k, idx, err, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.idx != idx || e.err != err || e.data !== d) begin
        n_err++;
        $display("FAIL event: got kind %0d idx %0d err %0d data 0x%0h, expected kind %0d idx %0d err %0d data 0x%0h",
                 k, idx, err, d, e.kind, e.idx, e.err, e.data);
      end
    end
  endtask

  logic [1:0] rv_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      rv_prev <= 2'b00;
    end else begin
      chk("push_pop_exclusive", 32'(stack_push & stack_pop), 32'd0);
      if (req_ready != 2'b00) see_ev(EV_ACK, int'(req_ready[1]), int'(|req_err), 32'd0);
      if (stack_push) see_ev(EV_PUSH, 0, 0, stack_in);
      if (stack_pop) see_ev(EV_POP, 0, 0, 32'd0);
      if ((resp_valid & ~rv_prev) != 2'b00) see_ev(EV_RESP, int'(resp_valid[1]), 0, resp_data);
      if (flush_done) see_ev(EV_FDONE, 0, 0, 32'd0);
      rv_prev <= resp_valid;
    end
  end

  task automatic do_req(input int r, input logic op, input logic [31:0] d, output int lat);
    @(negedge clk);
    req_valid[r] = 1'b1;
    req_op[r]    = op;
    if (r == 0) req_data0 = d; else req_data1 = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_ready[r] && lat < 20);
    if (!req_ready[r]) begin
      n_cmp++; n_err++;
      $display("FAIL req_timeout: requester %0d got no req_ready, expected one within 20 cycles", r);
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic run_flush(input int n);
    int pops, first, done, cyc;
    pops = 0; first = -1; done = -1; cyc = 0;
    for (int i = 0; i < n; i++) exp_ev(EV_POP, 0, 0, 32'd0);
    exp_ev(EV_FDONE, 0, 0, 32'd0);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    while (done < 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (stack_pop) begin
        pops++;
        if (first < 0) first = cyc;
      end
      if (flush_done) done = cyc;
    end
    chk("flush_pops", 32'(pops), 32'(n));
    chk("flush_done_seen", 32'(done >= 0), 32'd1);
    if (n > 0) chk("flush_pop_run", 32'(done - first), 32'(n));
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_req_err"}, 32'(req_err), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_strobes"}, 32'({stack_push, stack_pop, flush_done}), 32'd0);
    chk({tag, "_stack_in"}, stack_in, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_flags"}, 32'({full, empty, err_sticky}), 32'd0);
  endtask

  initial begin
    int lat, cyc;
    int g[2];
    int k0, k1;
    req_valid = 2'b00; req_op = 2'b00; req_data0 = '0; req_data1 = '0;
    resp_ready = 2'b11; flush = 1'b0; err_clr = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Push then pop one entry on requester 0.
    exp_ev(EV_ACK, 0, 0, 32'd0);
    exp_ev(EV_PUSH, 0, 0, 32'hA5A5_0001);
    do_req(0, OP_PUSH, 32'hA5A5_0001, lat);
    chk("push_latency", 32'(lat), 32'd1);
    chk("count_after_push", 32'(count), 32'd1);
    chk("empty_after_push", 32'(empty), 32'd0);

    exp_ev(EV_ACK, 0, 0, 32'd0);
    exp_ev(EV_POP, 0, 0, 32'd0);
    exp_ev(EV_RESP, 0, 0, 32'hA5A5_0001);
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = OP_POP;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end while (!resp_valid[0] && lat < 20);
    req_valid[0] = 1'b0;
    chk("pop_resp_latency", 32'(lat), 32'd3);
    chk("pop_resp_data", resp_data, 32'hA5A5_0001);
    chk("count_after_pop", 32'(count), 32'd0);
    @(negedge clk);

    // Fill to depth, then overflow.
    for (int i = 0; i < 31; i++) begin
      exp_ev(EV_ACK, 0, 0, 32'd0);
      exp_ev(EV_PUSH, 0, 0, 32'h1000 + 32'(i));
      do_req(0, OP_PUSH, 32'h1000 + 32'(i), lat);
    end
    chk("count_full", 32'(count), 32'd31);
    chk("full_flag", 32'(full), 32'd1);
    exp_ev(EV_ACK, 0, 1, 32'd0);
    do_req(0, OP_PUSH, 32'hDEAD_0032, lat);
    chk("overflow_sticky", 32'(err_sticky), 32'd1);
    chk("overflow_count", 32'(count), 32'd31);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr", 32'(err_sticky), 32'd0);

    // err_clr held across a new overflow: the set must win.
    err_clr = 1'b1;
    exp_ev(EV_ACK, 0, 1, 32'd0);
    do_req(0, OP_PUSH, 32'hDEAD_0033, lat);
    err_clr = 1'b0;
    chk("set_wins_over_clr", 32'(err_sticky), 32'd1);

    run_flush(31);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Underflow from the exception unit.
    exp_ev(EV_ACK, 1, 1, 32'd0);
    do_req(1, OP_POP, 32'd0, lat);
    chk("underflow_count", 32'(count), 32'd0);
    chk("underflow_sticky", 32'(err_sticky), 32'd1);
    repeat (4) @(negedge clk);
    chk("underflow_no_resp", 32'(resp_valid), 32'd0);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Both requesters push back to back.
    k0 = 0; k1 = 0;
    for (int i = 0; i < 5; i++) begin
      exp_ev(EV_ACK, order[i], 0, 32'd0);
      if (order[i] == 0) begin
        exp_ev(EV_PUSH, 0, 0, 32'h100 + 32'(k0)); k0++;
      end else begin
        exp_ev(EV_PUSH, 0, 0, 32'h200 + 32'(k1)); k1++;
      end
    end
    @(negedge clk);
    req_op = 2'b00; req_data0 = 32'h100; req_data1 = 32'h200; req_valid = 2'b11;
    g[0] = 0; g[1] = 0; cyc = 0;
    while (req_valid != 2'b00 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int r = 0; r < 2; r++) begin
        if (req_ready[r]) begin
          g[r]++;
          if (g[r] == quota[r]) req_valid[r] = 1'b0;
          else if (r == 0) req_data0 = 32'h100 + 32'(g[0]);
          else req_data1 = 32'h200 + 32'(g[1]);
        end
      end
    end
    chk("dual_push_done", 32'(req_valid), 32'd0);
    req_valid = 2'b00;
    chk("dual_push_count", 32'(count), 32'd5);

    run_flush(5);
    run_flush(0);

    // Reset while a response is pending.
    resp_ready = 2'b10;
    exp_ev(EV_ACK, 0, 0, 32'd0);
    exp_ev(EV_PUSH, 0, 0, 32'hC0DE_0001);
    do_req(0, OP_PUSH, 32'hC0DE_0001, lat);
    exp_ev(EV_ACK, 0, 0, 32'd0);
    exp_ev(EV_POP, 0, 0, 32'd0);
    exp_ev(EV_RESP, 0, 0, 32'hC0DE_0001);
    do_req(0, OP_POP, 32'd0, lat);
    cyc = 0;
    while (!resp_valid[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    chk("resp_held", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("resp_drop_async", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    resp_ready = 2'b11;
    @(negedge clk);
    chk("post_reset_count", 32'(count), 32'd0);
    chk("post_reset_resp", 32'(resp_valid), 32'd0);
    chk("post_reset_strobes", 32'({stack_push, stack_pop, req_ready}), 32'd0);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
